// File: rtl/mapped_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO, programmable baud divisor and an 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1) and set the STATUS capability flag.
module mapped_uart_tx #(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [15:0] addr,
    input  logic [7:0]  writedata,
    output logic [7:0]  memdata,
    output logic        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_CAP = 1'b1;
`else
    localparam logic PARITY_CAP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovr_q, ovr_d;
    logic [15:0] divisor_q, divisor_d;
    logic [7:0]  memdata_q, memdata_d;

    logic        fifo_empty, fifo_full;
    logic        push_req, push, pop;
    logic        bit_done, busy;
    logic [15:0] div_eff;
    logic [7:0]  head;
    logic [7:0]  rdata;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[15:2];

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    assign push_req = memwrite && (addr[1:0] == 2'd0);
    assign push     = push_req && (!fifo_full || pop);
    assign div_eff  = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
    assign bit_done = (cnt_q == div_lat_q - 16'd1);
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_lat_d = div_lat_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pop       = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_done ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = head;
                    par_d     = ^head;
                    div_lat_d = div_eff;
                    cnt_d     = 16'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    // Chain straight into the next frame so back-to-back bytes have no idle gap.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = head;
                        par_d     = ^head;
                        div_lat_d = div_eff;
                        cnt_d     = 16'd0;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (push ? (AW+1)'(1) : (AW+1)'(0));
        rd_ptr_d  = rd_ptr_q + (pop ? (AW+1)'(1) : (AW+1)'(0));
        ovr_d     = ovr_q;
        divisor_d = divisor_q;

        if (memwrite) begin
            case (addr[1:0])
                2'd1:    ovr_d = 1'b0;
                2'd2:    divisor_d[7:0]  = writedata;
                2'd3:    divisor_d[15:8] = writedata;
                default: ovr_d = ovr_q;
            endcase
        end
        if (push_req && !push) begin
            ovr_d = 1'b1;
        end

        case (addr[1:0])
            2'd1:    rdata = {PARITY_CAP, 3'b000, ovr_q, busy, fifo_empty, fifo_full};
            2'd2:    rdata = divisor_q[7:0];
            2'd3:    rdata = divisor_q[15:8];
            default: rdata = 8'h00;
        endcase
        memdata_d = memread ? rdata : memdata_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            div_lat_q <= 16'd1;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovr_q     <= 1'b0;
            divisor_q <= 16'(CLKS_PER_BIT);
            memdata_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_lat_q <= div_lat_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovr_q     <= ovr_d;
            divisor_q <= divisor_d;
            memdata_q <= memdata_d;
        end
    end

    assign memdata = memdata_q;
    assign tx      = tx_q;

endmodule
